// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the synchronous FIFO: owns the read pointer,
// drives the synchronous-read memory port and presents data to the consumer
// either one cycle after request (standard) or first-word-fall-through.
module fifo_read_ctrl #(
    parameter int unsigned MEM_DEPTH  = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    input  logic                  rd_ready,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  rd_underflow
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_mem_level;
    logic             w_mem_empty;
    logic             w_mem_rd_en;
    logic [PTR_W-1:0] w_rd_level;

    // Pointer difference with the extra wrap bit gives 0..MEM_DEPTH words in memory.
    assign w_mem_level = wr_ptr - r_rd_ptr;
    assign w_mem_empty = (w_mem_level == '0);

    // Read pointer advances once per memory read and wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
        end else if (w_mem_rd_en) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    if (FWFT == 0) begin : g_std
        logic r_valid;
        logic r_underflow;

        assign w_mem_rd_en = rd_ready & ~w_mem_empty;

        // Data lands one cycle after the strobe; a request while empty flags underflow.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid     <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                r_valid     <= w_mem_rd_en;
                r_underflow <= rd_ready & w_mem_empty;
            end
        end

        assign rd_valid     = r_valid;
        assign rd_data      = mem_rd_data;
        assign rd_empty     = w_mem_empty;
        assign w_rd_level   = w_mem_level;
        assign rd_underflow = r_underflow;
    end else begin : g_fwft
        logic                  r_hold_valid;
        logic                  r_fetch_pending;
        logic [DATA_WIDTH-1:0] r_hold_reg;
        logic                  w_valid;
        logic                  w_pop;
        logic                  w_capture;

        // Head word is either arriving from memory now or parked in the hold register.
        assign w_valid     = r_hold_valid | r_fetch_pending;
        assign w_pop       = rd_ready & w_valid;
        assign w_mem_rd_en = ~w_mem_empty & (~w_valid | w_pop);
        assign w_capture   = r_fetch_pending & ~w_pop;

        // One-word output stage: park an unconsumed fetch, release on pop.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_fetch_pending <= 1'b0;
                r_hold_valid    <= 1'b0;
                r_hold_reg      <= '0;
            end else begin
                r_fetch_pending <= w_mem_rd_en;
                if (w_capture) begin
                    r_hold_reg   <= mem_rd_data;
                    r_hold_valid <= 1'b1;
                end else if (w_pop) begin
                    r_hold_valid <= 1'b0;
                end
            end
        end

        assign rd_valid     = w_valid;
        assign rd_data      = r_fetch_pending ? mem_rd_data : r_hold_reg;
        assign rd_empty     = ~w_valid;
        assign w_rd_level   = w_mem_level + PTR_W'(w_valid);
        assign rd_underflow = 1'b0;
    end

    assign mem_rd_en       = w_mem_rd_en;
    assign rd_ptr          = r_rd_ptr;
    assign rd_addr         = r_rd_ptr[ADDR_WIDTH-1:0];
    assign rd_level        = w_rd_level;
    assign rd_almost_empty = (w_rd_level <= PTR_W'(AE_LEVEL));

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: a standard and a FWFT instance run side by side,
// each with its own memory and write pointer, checked against a queue model.
module tb_fifo_read_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned PW    = 5;
    localparam int unsigned AE    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [PW-1:0] s_wr_ptr, f_wr_ptr;
    logic          s_rd_ready, f_rd_ready;
    logic [DW-1:0] s_mem_rd_data = '0;
    logic [DW-1:0] f_mem_rd_data = '0;
    logic          s_mem_rd_en, f_mem_rd_en;
    logic [AW-1:0] s_rd_addr, f_rd_addr;
    logic [PW-1:0] s_rd_ptr, f_rd_ptr;
    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_rd_empty, f_rd_empty;
    logic          s_rd_ae, f_rd_ae;
    logic [PW-1:0] s_rd_level, f_rd_level;
    logic          s_rd_uf, f_rd_uf;

    logic [DW-1:0] s_mem [DEPTH];
    logic [DW-1:0] f_mem [DEPTH];

    fifo_read_ctrl #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AE_LEVEL(AE)) u_std (
        .clk(clk), .reset(reset), .wr_ptr(s_wr_ptr), .rd_ready(s_rd_ready),
        .mem_rd_data(s_mem_rd_data), .mem_rd_en(s_mem_rd_en), .rd_addr(s_rd_addr),
        .rd_ptr(s_rd_ptr), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .rd_empty(s_rd_empty),
        .rd_almost_empty(s_rd_ae), .rd_level(s_rd_level), .rd_underflow(s_rd_uf)
    );

    fifo_read_ctrl #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AE_LEVEL(AE)) u_fwft (
        .clk(clk), .reset(reset), .wr_ptr(f_wr_ptr), .rd_ready(f_rd_ready),
        .mem_rd_data(f_mem_rd_data), .mem_rd_en(f_mem_rd_en), .rd_addr(f_rd_addr),
        .rd_ptr(f_rd_ptr), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_empty(f_rd_empty),
        .rd_almost_empty(f_rd_ae), .rd_level(f_rd_level), .rd_underflow(f_rd_uf)
    );

    // Synchronous-read memories
    always @(posedge clk) if (s_mem_rd_en) s_mem_rd_data <= s_mem[s_rd_addr];
    always @(posedge clk) if (f_mem_rd_en) f_mem_rd_data <= f_mem[f_rd_addr];

    // Reference model state
    logic [DW-1:0] s_q[$];
    logic [DW-1:0] f_q[$];
    bit            s_exp_valid;
    bit            s_exp_uf;
    logic [DW-1:0] s_exp_data;
    int            s_popped;
    bit            f_vis;
    int            f_popped;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        s_rd_ready  = 1'b0;
        f_rd_ready  = 1'b0;
        s_wr_ptr    = '0;
        f_wr_ptr    = '0;
        s_q.delete();
        f_q.delete();
        s_exp_valid = 1'b0;
        s_exp_uf    = 1'b0;
        s_exp_data  = '0;
        s_popped    = 0;
        f_vis       = 1'b0;
        f_popped    = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One clock cycle: optional write into each FIFO, read request, then full check.
    task automatic cyc(input bit sw, input bit sr, input logic [DW-1:0] sd,
                       input bit fw, input bit fr, input logic [DW-1:0] fd);
        bit pop;
        int mem_words;
        @(posedge clk);
        #1;
        if (sw && s_q.size() < DEPTH) begin
            s_mem[s_wr_ptr[AW-1:0]] = sd;
            s_wr_ptr = s_wr_ptr + PW'(1);
            s_q.push_back(sd);
        end
        if (fw && f_q.size() < DEPTH) begin
            f_mem[f_wr_ptr[AW-1:0]] = fd;
            f_wr_ptr = f_wr_ptr + PW'(1);
            f_q.push_back(fd);
        end
        s_rd_ready = sr;
        f_rd_ready = fr;
        #1;
        // standard mode
        check_eq("s_valid", 32'(s_rd_valid), 32'(s_exp_valid));
        if (s_exp_valid) check_eq("s_data", 32'(s_rd_data), 32'(s_exp_data));
        check_eq("s_underflow", 32'(s_rd_uf), 32'(s_exp_uf));
        check_eq("s_level", 32'(s_rd_level), 32'(s_q.size()));
        check_eq("s_empty", 32'(s_rd_empty), 32'(s_q.size() == 0));
        check_eq("s_almost_empty", 32'(s_rd_ae), 32'(s_q.size() <= AE));
        check_eq("s_mem_rd_en", 32'(s_mem_rd_en), 32'(sr && s_q.size() > 0));
        check_eq("s_rd_ptr", 32'(s_rd_ptr), 32'(s_popped % 32));
        check_eq("s_rd_addr", 32'(s_rd_addr), 32'(s_popped % 16));
        s_exp_uf    = sr && (s_q.size() == 0);
        s_exp_valid = sr && (s_q.size() > 0);
        if (s_exp_valid) begin
            s_exp_data = s_q.pop_front();
            s_popped++;
        end
        // FWFT mode
        mem_words = f_q.size() - int'(f_vis);
        pop = fr && f_vis;
        check_eq("f_valid", 32'(f_rd_valid), 32'(f_vis));
        if (f_vis) check_eq("f_data", 32'(f_rd_data), 32'(f_q[0]));
        check_eq("f_level", 32'(f_rd_level), 32'(f_q.size()));
        check_eq("f_empty", 32'(f_rd_empty), 32'(!f_vis));
        check_eq("f_almost_empty", 32'(f_rd_ae), 32'(f_q.size() <= AE));
        check_eq("f_underflow", 32'(f_rd_uf), 32'(0));
        check_eq("f_rd_ptr", 32'(f_rd_ptr), 32'((f_popped + int'(f_vis)) % 32));
        check_eq("f_mem_rd_en", 32'(f_mem_rd_en), 32'(mem_words > 0 && (!f_vis || pop)));
        if (pop) begin
            void'(f_q.pop_front());
            f_popped++;
        end
        f_vis = (f_q.size() > 0);
    endtask

    initial begin
        do_reset();
        #1;
        check_eq("rst_s_rd_ptr", 32'(s_rd_ptr), 32'(0));
        check_eq("rst_s_valid", 32'(s_rd_valid), 32'(0));
        check_eq("rst_s_mem_rd_en", 32'(s_mem_rd_en), 32'(0));
        check_eq("rst_s_underflow", 32'(s_rd_uf), 32'(0));
        check_eq("rst_f_valid", 32'(f_rd_valid), 32'(0));
        check_eq("rst_f_rd_ptr", 32'(f_rd_ptr), 32'(0));

        // standard: three words then four requests (last one underflows)
        cyc(1, 0, 8'hA1, 0, 0, 8'h00);
        cyc(1, 0, 8'hB2, 0, 0, 8'h00);
        cyc(1, 0, 8'hC3, 0, 0, 8'h00);
        repeat (4) cyc(0, 1, 8'h00, 0, 0, 8'h00);
        repeat (2) cyc(0, 0, 8'h00, 0, 0, 8'h00);

        // FWFT: single word falls through and stays stable while not popped
        do_reset();
        cyc(0, 0, 8'h00, 1, 0, 8'h5A);
        repeat (5) cyc(0, 0, 8'h00, 0, 0, 8'h00);
        cyc(0, 0, 8'h00, 0, 1, 8'h00);
        cyc(0, 0, 8'h00, 0, 0, 8'h00);

        // FWFT streaming from a full FIFO; standard side drains alongside
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'($urandom), 1, 0, 8'($urandom));
        repeat (19) cyc(0, 1, 8'h00, 0, 1, 8'h00);

        // write/read pairs crossing the pointer wrap
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1, 1, 8'($urandom), 1, 1, 8'($urandom));

        // random traffic with alternating fill/drain bias
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 300) % 2 == 0) ? 75 : 25;
            cyc($urandom_range(99) < wp, $urandom_range(99) < (100 - wp), 8'($urandom),
                $urandom_range(99) < wp, $urandom_range(99) < (100 - wp), 8'($urandom));
        end

        // reset while a FWFT fetch is in flight
        do_reset();
        cyc(0, 0, 8'h00, 1, 0, 8'h3C);
        cyc(0, 0, 8'h00, 0, 0, 8'h00);
        reset    = 1'b1;
        s_wr_ptr = '0;
        f_wr_ptr = '0;
        @(posedge clk);
        #1;
        check_eq("rst_mid_f_valid", 32'(f_rd_valid), 32'(0));
        check_eq("rst_mid_f_rd_ptr", 32'(f_rd_ptr), 32'(0));
        check_eq("rst_mid_f_level", 32'(f_rd_level), 32'(0));
        do_reset();
        repeat (3) cyc(0, 0, 8'h00, 0, 1, 8'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
